router_iact_mc: RTL and testbench
=================================

Name: router_iact_mc

Overview:
- Multi-destination input-activation router. Reads a contiguous block of iact words from the global buffer (GLB) and writes them into the scratchpads (spads) of up to NUM_PE processing elements.
- Two modes: broadcast (every word to all selected PEs) and scatter (consecutive sub-blocks to successive selected PEs).
- Tolerates a fixed GLB read latency and per-PE spad backpressure through a small credit-controlled skid FIFO.
- Sits between the GLB and the PE-array spads and is started by the control unit.

Parameters:
- DATA_BITWIDTH, 16, iact word width
- ADDR_BITWIDTH_GLB, 10, GLB address width
- ADDR_BITWIDTH_SPAD, 9, spad address width; also the width of num_words
- NUM_PE, 3, number of destination spads
- GLB_READ_LATENCY, 1, cycles from read_req_glb_iact to valid r_data_glb_iact (1..4)
- FIFO_DEPTH, 4, skid FIFO entries; must be ≥ GLB_READ_LATENCY+1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_spad_ctrl  in  1  start pulse; sampled only in IDLE
- mode_scatter  in  1  0 = broadcast, 1 = scatter; latched at start
- dest_mask  in  NUM_PE  destination PE select; latched at start
- base_addr_glb  in  ADDR_BITWIDTH_GLB  first GLB address; latched at start
- num_words  in  ADDR_BITWIDTH_SPAD  words per destination PE; latched at start
- r_data_glb_iact  in  DATA_BITWIDTH  GLB read data
- r_addr_glb_iact  out  ADDR_BITWIDTH_GLB  GLB read address
- read_req_glb_iact  out  1  GLB read strobe, one word per cycle when high
- spad_ready  in  NUM_PE  per-PE spad accept
- w_data_spad  out  DATA_BITWIDTH  shared spad write data
- w_addr_spad  out  ADDR_BITWIDTH_SPAD  spad write address
- load_en_spad  out  NUM_PE  per-PE write strobe
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-low) clears all outputs, counters, FIFO pointers and the latency shift register to 0, and puts the FSM in IDLE. In-flight GLB data is discarded. Reset may assert in any state.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On load_spad_ctrl=1, latch the configuration and set busy=1.
  - total = num_words in broadcast; num_words × popcount(dest_mask) in scatter. The internal counter is wide enough for the worst case.
  - If total==0 (num_words==0 or dest_mask==0): go to DONE, issue no reads. Otherwise go to RUN.
- RUN (read issue):
  - read_req_glb_iact=1 in a cycle only if issued < total and (fifo_count + in_flight) < FIFO_DEPTH.
  - r_addr_glb_iact = base + issued, wrapping modulo 2^ADDR_BITWIDTH_GLB.
  - Each issue pushes a token into a GLB_READ_LATENCY-deep valid shift register. When the token emerges, r_data_glb_iact is pushed into the FIFO in that same cycle.
  - When issued == total, go to DRAIN.
- Write side (RUN and DRAIN):
  - target = dest_mask in broadcast; one-hot of the current PE in scatter. The current PE is the lowest set bit of dest_mask, advancing to the next set bit after num_words writes.
  - A write fires when the FIFO is non-empty and spad_ready is high for every PE in target.
  - On a write, in the same cycle: load_en_spad = target, w_data_spad = FIFO head, w_addr_spad = spad_idx; pop the FIFO.
  - spad_idx increments per write and returns to 0 on a scatter PE switch.
  - When no write fires, load_en_spad = 0; w_data_spad and w_addr_spad hold.
  - Simultaneous push and pop in one cycle is legal; fifo_count is unchanged.
- DRAIN: no reads. When written == total, go to DONE.
- DONE: done=1 for one cycle, busy=0, read_req_glb_iact=0, then IDLE.
- load_spad_ctrl asserted outside IDLE is ignored.
- The FIFO never overflows by construction of the credit check. FIFO overflow or a pop when empty is a bug; the bench asserts against both.
- Word order on the spad side equals GLB address order.
- Latency, no backpressure, broadcast: first load_en_spad occurs GLB_READ_LATENCY+1 cycles after the first read_req_glb_iact, then one write per cycle.

Test Plan:
- Broadcast, base=100, num_words=25, dest_mask=3'b111, spad_ready=all 1, latency 1 → reads addresses 100..124 on consecutive cycles; 25 writes with load_en_spad=3'b111, w_addr_spad 0..24, data matching GLB[100..124]; done pulse once; busy falls.
- Scatter, base=100, num_words=4, dest_mask=3'b101 → PE0 receives GLB[100..103] at addresses 0..3; PE2 receives GLB[104..107] at addresses 0..3; PE1 never strobed.
- Backpressure: broadcast 16 words, spad_ready[1]=0 for 6 cycles mid-stream → no writes while low; read_req_glb_iact drops once credits are exhausted; no lost or duplicated words; order preserved.
- num_words=0 (and separately dest_mask=0) → no read_req_glb_iact; done pulses 2 cycles after start.
- Wrap: base=1022, num_words=4, GLB_READ_LATENCY=2 → addresses 1022, 1023, 0, 1; data correct with the 2-cycle latency.
- Reset asserted asynchronously mid-RUN → all outputs 0 without waiting for a clock edge; after release, a new broadcast of 3 words completes correctly with no stale FIFO data.

Source files
------------

// File: rtl/router_iact_mc.sv
// Input-activation router: streams a contiguous GLB block into up to NUM_PE spads,
// broadcasting every word or scattering consecutive sub-blocks across the selected PEs.
module router_iact_mc #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_GLB  = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int NUM_PE             = 3,
    parameter int GLB_READ_LATENCY   = 1,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_spad_ctrl,
    input  logic                          mode_scatter,
    input  logic [NUM_PE-1:0]             dest_mask,
    input  logic [ADDR_BITWIDTH_GLB-1:0]  base_addr_glb,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] num_words,
    input  logic [DATA_BITWIDTH-1:0]      r_data_glb_iact,
    output logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_glb_iact,
    output logic                          read_req_glb_iact,
    input  logic [NUM_PE-1:0]             spad_ready,
    output logic [DATA_BITWIDTH-1:0]      w_data_spad,
    output logic [ADDR_BITWIDTH_SPAD-1:0] w_addr_spad,
    output logic [NUM_PE-1:0]             load_en_spad,
    output logic                          busy,
    output logic                          done
);
    localparam int L   = GLB_READ_LATENCY;
    localparam int PCW = $clog2(NUM_PE + 1);
    localparam int TW  = ADDR_BITWIDTH_SPAD + PCW;
    localparam int PW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IFW = $clog2(L + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [PCW-1:0] popcnt(input logic [NUM_PE-1:0] m);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_PE; i++) c = c + PCW'(m[i]);
        return c;
    endfunction

    // Lowest set bit of m strictly above index 'from' (from = -1 gives the first one).
    function automatic logic [PW-1:0] next_set(input logic [NUM_PE-1:0] m, input int from);
        logic [PW-1:0] r;
        r = '0;
        for (int i = NUM_PE - 1; i >= 0; i--)
            if (m[i] && i > from) r = PW'(i);
        return r;
    endfunction

    logic [1:0]                    state;
    logic                          cfg_scatter;
    logic [NUM_PE-1:0]             cfg_mask;
    logic [ADDR_BITWIDTH_GLB-1:0]  cfg_base;
    logic [ADDR_BITWIDTH_SPAD-1:0] cfg_num;
    logic [TW-1:0]                 total, issued, written, total_in;
    logic [PW-1:0]                 cur_pe;
    logic [ADDR_BITWIDTH_SPAD-1:0] spad_idx, w_addr_q;
    logic [DATA_BITWIDTH-1:0]      w_data_q;
    logic [L:1]                    vld_pipe;
    logic [IFW-1:0]                in_flight;
    logic [DATA_BITWIDTH-1:0]      fifo_mem [FIFO_DEPTH];
    logic [FPW-1:0]                wptr, rptr;
    logic [CW-1:0]                 fifo_count;
    logic [CW:0]                   occ;
    logic [NUM_PE-1:0]             target;
    logic                          active, rd_fire, wr_fire, push;

    always_comb begin
        in_flight = '0;
        for (int i = 1; i <= L; i++) in_flight = in_flight + IFW'(vld_pipe[i]);
    end

    // Credits cover both queued words and reads still in the GLB pipeline.
    assign occ      = (CW+1)'(fifo_count) + (CW+1)'(in_flight);
    assign total_in = mode_scatter ? TW'(num_words) * TW'(popcnt(dest_mask)) : TW'(num_words);
    assign target   = cfg_scatter ? (NUM_PE'(1) << cur_pe) : cfg_mask;
    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign rd_fire  = (state == S_RUN) && (issued < total) && (occ < (CW+1)'(FIFO_DEPTH));
    assign wr_fire  = active && (fifo_count != '0) && ((spad_ready & target) == target);
    assign push     = vld_pipe[L];

    assign read_req_glb_iact = rd_fire;
    assign r_addr_glb_iact   = cfg_base + ADDR_BITWIDTH_GLB'(issued);
    assign load_en_spad      = wr_fire ? target : '0;
    assign w_data_spad       = wr_fire ? fifo_mem[rptr] : w_data_q;
    assign w_addr_spad       = wr_fire ? spad_idx : w_addr_q;
    assign busy              = active;
    assign done              = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= r_data_glb_iact;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cfg_scatter <= 1'b0;
            cfg_mask    <= '0;
            cfg_base    <= '0;
            cfg_num     <= '0;
            total       <= '0;
            issued      <= '0;
            written     <= '0;
            cur_pe      <= '0;
            spad_idx    <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            vld_pipe    <= '0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_count  <= '0;
        end else begin
            vld_pipe[1] <= rd_fire;
            for (int i = 2; i <= L; i++) vld_pipe[i] <= vld_pipe[i-1];

            if (push) wptr <= (wptr == FPW'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (wr_fire) rptr <= (rptr == FPW'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
            case ({push, wr_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            issued  <= issued + TW'(rd_fire);
            written <= written + TW'(wr_fire);

            if (wr_fire) begin
                w_data_q <= fifo_mem[rptr];
                w_addr_q <= spad_idx;
                if (cfg_scatter && spad_idx == cfg_num - 1'b1) begin
                    spad_idx <= '0;
                    cur_pe   <= next_set(cfg_mask, int'(cur_pe));
                end else begin
                    spad_idx <= spad_idx + 1'b1;
                end
            end

            case (state)
                S_IDLE: if (load_spad_ctrl) begin
                    cfg_scatter <= mode_scatter;
                    cfg_mask    <= dest_mask;
                    cfg_base    <= base_addr_glb;
                    cfg_num     <= num_words;
                    total       <= total_in;
                    issued      <= '0;
                    written     <= '0;
                    spad_idx    <= '0;
                    cur_pe      <= next_set(dest_mask, -1);
                    state       <= (num_words == '0 || dest_mask == '0) ? S_DONE : S_RUN;
                end
                S_RUN:   if (issued + TW'(rd_fire) == total) state <= S_DRAIN;
                S_DRAIN: if (written + TW'(wr_fire) == total) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_iact_mc.sv
// Bench for router_iact_mc: GLB memory model with fixed read latency, transaction
// scoreboard, and an expected write list built directly from the routing rules.
module tb_router_iact_mc;
    localparam int DW = 16, AG = 10, AS = 9, NP = 3, LAT = 2, DEPTH = 4;

    logic              clk = 1'b0, reset;
    logic              load_spad_ctrl, mode_scatter;
    logic [NP-1:0]     dest_mask, spad_ready, load_en_spad;
    logic [AG-1:0]     base_addr_glb, r_addr_glb_iact;
    logic [AS-1:0]     num_words, w_addr_spad;
    logic [DW-1:0]     r_data_glb_iact, w_data_spad;
    logic              read_req_glb_iact, busy, done;

    always #5 clk = ~clk;

    router_iact_mc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AG), .ADDR_BITWIDTH_SPAD(AS),
                     .NUM_PE(NP), .GLB_READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_spad_ctrl(load_spad_ctrl), .mode_scatter(mode_scatter),
        .dest_mask(dest_mask), .base_addr_glb(base_addr_glb), .num_words(num_words),
        .r_data_glb_iact(r_data_glb_iact), .r_addr_glb_iact(r_addr_glb_iact),
        .read_req_glb_iact(read_req_glb_iact), .spad_ready(spad_ready),
        .w_data_spad(w_data_spad), .w_addr_spad(w_addr_spad), .load_en_spad(load_en_spad),
        .busy(busy), .done(done));

    logic [DW-1:0] glb_mem [1024];
    logic [AG-1:0] addr_q [LAT];
    always @(posedge clk) begin
        addr_q[0] <= r_addr_glb_iact;
        for (int i = 1; i < LAT; i++) addr_q[i] <= addr_q[i-1];
    end
    assign r_data_glb_iact = glb_mem[addr_q[LAT-1]];

    typedef struct { logic [NP-1:0] en; int addr; int data; } wr_t;
    int  rd_q[$];
    wr_t wr_q[$];
    int  tests = 0, errs = 0, cyc = 0;
    int  done_cnt, first_rd, first_wr, stall_rd, stall_wr;
    bit  stall_win = 0, rdy_rand = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (read_req_glb_iact) begin
                rd_q.push_back(int'(r_addr_glb_iact));
                if (first_rd < 0) first_rd = cyc;
                if (stall_win) stall_rd++;
            end
            if (load_en_spad != '0) begin
                wr_q.push_back('{load_en_spad, int'(w_addr_spad), int'(w_data_spad)});
                if (first_wr < 0) first_wr = cyc;
                if (stall_win) stall_wr++;
                chk("pop_nonempty", 64'(dut.fifo_count != 0), 1);
            end
            if (busy) chk("fifo_no_ovf", 64'(dut.fifo_count <= DEPTH), 1);
            if (done) done_cnt++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) spad_ready = NP'(~($urandom & $urandom));
    end

    task automatic run_cfg(input bit sc, input logic [NP-1:0] mask, input int base, input int n,
                           input bit lat_chk, input bit stall);
        int got, total, idx;
        bit stalled;
        wr_t exp_q[$];
        rd_q.delete(); wr_q.delete();
        done_cnt = 0; first_rd = -1; first_wr = -1; stall_rd = 0; stall_wr = 0;
        got = 0; stalled = 0;
        @(posedge clk); #1;
        mode_scatter = sc; dest_mask = mask; base_addr_glb = AG'(base); num_words = AS'(n);
        load_spad_ctrl = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (done) begin got = k; break; end
            if (k == 1) begin
                // scramble config after the start pulse: the run must use latched values
                @(posedge clk); #1;
                load_spad_ctrl = 1'b0;
                mode_scatter = 1'($urandom); dest_mask = NP'($urandom);
                base_addr_glb = AG'($urandom); num_words = AS'($urandom);
            end
            if (stall && !stalled && wr_q.size() >= 4) begin
                stalled = 1;
                @(posedge clk); #1;
                spad_ready = 3'b101; stall_win = 1;
                repeat (6) @(posedge clk);
                #1 spad_ready = '1; stall_win = 0;
            end
        end
        load_spad_ctrl = 1'b0;
        repeat (3) @(negedge clk);

        total = (mask == '0 || n == 0) ? 0 : (sc ? n * $countones(mask) : n);
        chk("done_seen", 64'(got != 0), 1);
        chk("done_once", 64'(done_cnt), 1);
        chk("busy_idle", 64'(busy), 0);
        if (total == 0) chk("zero_done_cyc", 64'(got), 2);

        chk("rd_count", 64'(rd_q.size()), 64'(total));
        for (int i = 0; i < rd_q.size() && i < total; i++)
            chk("rd_addr", 64'(rd_q[i]), 64'((base + i) % 1024));

        if (total > 0) begin
            if (!sc) begin
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{mask, i, int'(glb_mem[(base + i) % 1024])});
            end else begin
                idx = 0;
                for (int p = 0; p < NP; p++)
                    if (mask[p])
                        for (int j = 0; j < n; j++) begin
                            exp_q.push_back('{NP'(1) << p, j, int'(glb_mem[(base + idx) % 1024])});
                            idx++;
                        end
            end
        end
        chk("wr_count", 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            chk("wr_en",   64'(wr_q[i].en),   64'(exp_q[i].en));
            chk("wr_addr", 64'(wr_q[i].addr), 64'(exp_q[i].addr));
            chk("wr_data", 64'(wr_q[i].data), 64'(exp_q[i].data));
        end
        if (lat_chk) chk("first_wr_lat", 64'(first_wr - first_rd), 64'(LAT + 1));
        if (stall) begin
            chk("stall_seen", 64'(stalled), 1);
            chk("stall_no_wr", 64'(stall_wr), 0);
            chk("stall_rd_drop", 64'(stall_rd < 6), 1);
            chk("stall_rd_credit", 64'(stall_rd <= DEPTH), 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) glb_mem[i] = DW'($urandom);
        for (int i = 0; i < LAT; i++) addr_q[i] = '0;
        reset = 1'b0; load_spad_ctrl = 1'b0; mode_scatter = 1'b0; dest_mask = '0;
        base_addr_glb = '0; num_words = '0; spad_ready = '1;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_req", 64'(read_req_glb_iact), 0);
        chk("rst_en", 64'(load_en_spad), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_cfg(0, 3'b111, 100, 25, 1, 0);
        run_cfg(1, 3'b101, 100, 4, 0, 0);
        run_cfg(0, 3'b111, 200, 16, 0, 1);
        run_cfg(0, 3'b111, 300, 0, 0, 0);
        run_cfg(1, 3'b000, 300, 5, 0, 0);
        run_cfg(0, 3'b000, 300, 5, 0, 0);
        run_cfg(0, 3'b111, 1022, 4, 1, 0);
        run_cfg(1, 3'b110, 1021, 3, 0, 0);

        // asynchronous reset in the middle of a broadcast
        @(posedge clk); #1;
        mode_scatter = 1'b0; dest_mask = 3'b111; base_addr_glb = AG'(40); num_words = AS'(25);
        load_spad_ctrl = 1'b1;
        @(posedge clk); #1 load_spad_ctrl = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_req", 64'(read_req_glb_iact), 0);
        chk("arst_en", 64'(load_en_spad), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_wdata", 64'(w_data_spad), 0);
        chk("arst_waddr", 64'(w_addr_spad), 0);
        chk("arst_raddr", 64'(r_addr_glb_iact), 0);
        @(negedge clk); #1 reset = 1'b1;
        run_cfg(0, 3'b111, 500, 3, 1, 0);

        rdy_rand = 1;
        for (int t = 0; t < 12; t++)
            run_cfg(1'($urandom), NP'($urandom_range(0, 7)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 9)), 0, 0);
        rdy_rand = 0; spad_ready = '1;

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
